// File: rtl/noc_in_if.sv
// Router input-port link bundle: upstream flit/credit link, switch-allocator
// handshake, and crossbar output.
interface noc_in_if #(
  parameter int unsigned FLIT_W = 32
);
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              credit_out;
  logic              ds_ready;
  logic              req;
  logic [2:0]        route_sel;
  logic              grant;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic              err;

  // Upstream link, allocator and downstream side.
  modport master (
    output in_valid, in_flit, ds_ready, grant,
    input  credit_out, req, route_sel, out_valid, out_flit, err
  );

  // The input unit itself.
  modport slave (
    input  in_valid, in_flit, ds_ready, grant,
    output credit_out, req, route_sel, out_valid, out_flit, err
  );
endinterface

// File: rtl/noc_input_unit.sv
// Router input port: flit FIFO, per-packet XY route computation, switch-allocator
// request generation and wormhole forwarding with credit return upstream.
module noc_input_unit #(
  parameter int unsigned FLIT_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COORD_W = 3,
  parameter int unsigned CUR_X   = 0,
  parameter int unsigned CUR_Y   = 0
) (
  input logic   clk,
  input logic   rst,
  noc_in_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [COORD_W-1:0] CUR_XC = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CUR_YC = COORD_W'(CUR_Y);

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_EAST  = 3'd1;
  localparam logic [2:0] PORT_WEST  = 3'd2;
  localparam logic [2:0] PORT_NORTH = 3'd3;
  localparam logic [2:0] PORT_SOUTH = 3'd4;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_d;

  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;

  logic [FLIT_W-1:0]  head;
  logic [1:0]         head_type;
  logic               is_head, is_tail;
  logic               empty, full;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic [2:0]         route_d, route_q;

  logic pop_fwd, stray, bad_grant, latch_route;
  logic pop, push, overflow;

  logic              out_valid_q;
  logic [FLIT_W-1:0] out_flit_q;
  logic              credit_q;
  logic              err_q;

  assign head      = mem[rd_ptr];
  assign head_type = head[FLIT_W-1 -: 2];
  assign is_head   = head_type[0];
  assign is_tail   = head_type[1];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign dest_x    = head[COORD_W-1:0];
  assign dest_y    = head[2*COORD_W-1 -: COORD_W];

  // Dimension-ordered routing: resolve X completely before Y.
  always_comb begin
    route_d = PORT_LOCAL;
    if (dest_x > CUR_XC)      route_d = PORT_EAST;
    else if (dest_x < CUR_XC) route_d = PORT_WEST;
    else if (dest_y > CUR_YC) route_d = PORT_NORTH;
    else if (dest_y < CUR_YC) route_d = PORT_SOUTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state plus the pop/error decisions that depend on it.
  always_comb begin
    state_d     = state;
    pop_fwd     = 1'b0;
    stray       = 1'b0;
    bad_grant   = 1'b0;
    latch_route = 1'b0;
    case (state)
      IDLE: begin
        if (bus.grant) bad_grant = 1'b1;
        if (!empty) begin
          if (is_head) begin
            latch_route = 1'b1;
            state_d     = ACTIVE;
          end else begin
            stray = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.grant) begin
          if (empty) begin
            bad_grant = 1'b1;
          end else begin
            pop_fwd = 1'b1;
            if (is_tail) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop      = pop_fwd || stray;
  assign push     = bus.in_valid && (!full || pop);
  assign overflow = bus.in_valid && full && !pop;

  // Suppression keeps a grant that will arrive next cycle from hitting an
  // empty buffer or the head of the following packet.
  assign bus.req = (state == ACTIVE) && !empty && bus.ds_ready &&
                   !(bus.grant && ((count == CNT_W'(1)) || is_tail));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      route_q     <= PORT_LOCAL;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      credit_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (latch_route) route_q <= route_d;
      out_valid_q <= pop_fwd;
      if (pop_fwd) out_flit_q <= head;
      credit_q <= pop;
      err_q    <= overflow || stray || bad_grant;
    end
  end

  assign bus.route_sel  = route_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_flit   = out_flit_q;
  assign bus.credit_out = credit_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_noc_input_unit.sv
// Directed bench for noc_input_unit: two instances (router at (2,2) and at (0,0))
// share one stimulus stream and are checked every cycle against a queue model.
module tb_noc_input_unit;

  localparam int unsigned FW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  noc_in_if #(.FLIT_W(FW)) bus ();
  noc_in_if #(.FLIT_W(FW)) bus0 ();

  noc_input_unit #(.FLIT_W(FW), .DEPTH(DEPTH), .COORD_W(3), .CUR_X(2), .CUR_Y(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  noc_input_unit #(.FLIT_W(FW), .DEPTH(DEPTH), .COORD_W(3), .CUR_X(0), .CUR_Y(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  assign bus0.in_valid = bus.in_valid;
  assign bus0.in_flit  = bus.in_flit;
  assign bus0.ds_ready = bus.ds_ready;
  assign bus0.grant    = bus.grant;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] t, input int dx, input int dy, input int tag);
    return {t, 24'(tag), 3'(dy), 3'(dx)};
  endfunction

  function automatic int xy(input logic [31:0] f, input int cx, input int cy);
    int dx, dy;
    dx = int'(f[2:0]);
    dy = int'(f[5:3]);
    if (dx > cx) return 1;
    if (dx < cx) return 2;
    if (dy > cy) return 3;
    if (dy < cy) return 4;
    return 0;
  endfunction

  // Packet-level model: a bounded queue of flits plus "inside a packet" flag.
  logic [31:0] mq[$];
  bit          m_act;
  int          m_r22, m_r00;
  bit          m_ov, m_cr, m_err;
  bit   [31:0] m_of;
  int          cyc = 0;
  bit          fwd, drop, bad, ovf;
  logic [31:0] h;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_act = 0; m_r22 = 0; m_r00 = 0;
      m_ov = 0; m_cr = 0; m_err = 0; m_of = '0;
    end else begin
      cyc++;
      fwd = 0; drop = 0; bad = 0; ovf = 0;
      h = (mq.size() > 0) ? mq[0] : '0;
      if (!m_act) begin
        if (bus.grant) bad = 1;
        if (mq.size() > 0) begin
          if (h[30]) begin
            m_act = 1;
            m_r22 = xy(h, 2, 2);
            m_r00 = xy(h, 0, 0);
          end else begin
            drop = 1;
          end
        end
      end else if (bus.grant) begin
        if (mq.size() == 0) bad = 1;
        else begin
          fwd = 1;
          if (h[31]) m_act = 0;
        end
      end
      if (fwd || drop) void'(mq.pop_front());
      if (bus.in_valid) begin
        if (mq.size() < DEPTH) mq.push_back(bus.in_flit);
        else ovf = 1;
      end
      m_ov  = fwd;
      if (fwd) m_of = h;
      m_cr  = fwd || drop;
      m_err = bad || drop || ovf;
    end
  end

  function automatic bit exp_req();
    bit last_or_tail;
    if (!m_act || mq.size() == 0 || !bus.ds_ready) return 0;
    last_or_tail = (mq.size() == 1) || mq[0][31];
    return !(bus.grant && last_or_tail);
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",          32'(bus.req),        32'(exp_req()));
      chk("req0",         32'(bus0.req),       32'(exp_req()));
      chk("out_valid",    32'(bus.out_valid),  32'(m_ov));
      chk("out_valid0",   32'(bus0.out_valid), 32'(m_ov));
      chk("out_flit",     bus.out_flit,        m_of);
      chk("out_flit0",    bus0.out_flit,       m_of);
      chk("credit_out",   32'(bus.credit_out), 32'(m_cr));
      chk("credit_out0",  32'(bus0.credit_out),32'(m_cr));
      chk("err",          32'(bus.err),        32'(m_err));
      chk("err0",         32'(bus0.err),       32'(m_err));
      chk("route_sel",    32'(bus.route_sel),  32'(m_r22));
      chk("route_sel0",   32'(bus0.route_sel), 32'(m_r00));
    end
  end

  // Stimulus helpers; the allocator answers the previous cycle's req.
  bit auto_grant = 1;
  bit man_grant  = 0;
  bit last_req   = 0;
  logic [31:0] obs[$];
  int          obs_cyc[$];
  int          cred_cyc[$];

  task automatic tick();
    @(negedge clk);
    last_req = bus.req;
    @(posedge clk);
    #1;
    bus.grant = auto_grant ? last_req : man_grant;
  endtask

  task automatic send(input logic [31:0] f);
    bus.in_valid = 1'b1;
    bus.in_flit  = f;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        obs.push_back(bus.out_flit);
        obs_cyc.push_back(cyc);
      end
      if (bus.credit_out === 1'b1) cred_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_cyc.delete();
    cred_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int dx; int dy; int r22; int r00;
  } route_vec_t;

  route_vec_t rv[8];
  logic [31:0] f1, pk[3], buf4[4], tl, ff;
  int wcyc;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_flit  = '0;
    bus.ds_ready = 1'b1;
    bus.grant    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("rst_req",       32'(bus.req),        0);
    chk("rst_out_valid", 32'(bus.out_valid),  0);
    chk("rst_credit",    32'(bus.credit_out), 0);
    chk("rst_err",       32'(bus.err),        0);
    chk("rst_route",     32'(bus.route_sel),  0);
    chk("rst_out_flit",  bus.out_flit,        0);
    #2 rst = 1'b0;
    tick();

    // Single head+tail flit to (2,0): 3-cycle latency, East from (0,0), South from (2,2)
    clear_obs();
    f1 = mk(2'b11, 2, 0, 24'h0000A1);
    send(f1);
    wcyc = cyc;
    run(8);
    chk("t1_nflits",      32'(obs.size()), 1);
    chk("t1_latency",     32'((obs.size() > 0) ? obs_cyc[0] - wcyc : -1), 3);
    chk("t1_credit_lat",  32'((cred_cyc.size() > 0) ? cred_cyc[0] - wcyc : -1), 3);
    chk("t1_flit",        (obs.size() > 0) ? obs[0] : 32'h0, f1);
    chk("t1_route00",     32'(bus0.route_sel), 1);
    chk("t1_route22",     32'(bus.route_sel),  4);
    chk("t1_req_idle",    32'(bus.req),        0);

    // 3-flit packet to (0,4), back-to-back
    clear_obs();
    pk[0] = mk(2'b01, 0, 4, 24'h000B01);
    pk[1] = mk(2'b00, 5, 5, 24'h000B02);
    pk[2] = mk(2'b10, 6, 1, 24'h000B03);
    for (int i = 0; i < 3; i++) send(pk[i]);
    run(10);
    chk("t2_nflits",   32'(obs.size()), 3);
    chk("t2_ncredit",  32'(cred_cyc.size()), 3);
    chk("t2_consec",   32'((obs.size() == 3) ? obs_cyc[2] - obs_cyc[0] : -1), 2);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_flit%0d", i), (obs.size() > i) ? obs[i] : 32'h0, pk[i]);
    chk("t2_route22", 32'(bus.route_sel),  2);
    chk("t2_route00", 32'(bus0.route_sel), 3);
    chk("t2_no_err",  32'(bus.err),        0);

    // Route sweep
    rv[0] = '{3, 2, 1, 1};
    rv[1] = '{1, 2, 2, 1};
    rv[2] = '{2, 3, 3, 1};
    rv[3] = '{2, 1, 4, 1};
    rv[4] = '{2, 2, 0, 1};
    rv[5] = '{1, 5, 2, 1};
    rv[6] = '{0, 0, 2, 0};
    rv[7] = '{0, 3, 2, 3};
    for (int i = 0; i < 8; i++) begin
      send(mk(2'b11, rv[i].dx, rv[i].dy, 24'h000C00 + i));
      run(5);
      chk($sformatf("sweep%0d_r22", i), 32'(bus.route_sel),  32'(rv[i].r22));
      chk($sformatf("sweep%0d_r00", i), 32'(bus0.route_sel), 32'(rv[i].r00));
    end

    // Backpressure: 4 buffered, 5th write overflows, then drain in order
    clear_obs();
    bus.ds_ready = 1'b0;
    buf4[0] = mk(2'b01, 3, 3, 24'h000D00);
    for (int i = 1; i < 4; i++) buf4[i] = mk(2'b00, i, 7 - i, 24'h000D00 + i);
    for (int i = 0; i < 4; i++) send(buf4[i]);
    chk("t4_req_blocked", 32'(bus.req), 0);
    chk("t4_no_err_yet",  32'(bus.err), 0);
    send(mk(2'b00, 7, 7, 24'h000DFF));
    chk("t4_ovf_err",     32'(bus.err), 1);
    run(2);
    chk("t4_still_held",  32'(obs.size()), 0);
    bus.ds_ready = 1'b1;
    run(10);
    chk("t4_ndrain", 32'(obs.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_flit%0d", i), (obs.size() > i) ? obs[i] : 32'h0, buf4[i]);
    tl = mk(2'b10, 0, 0, 24'h000DEE);
    send(tl);
    run(6);
    chk("t4_tail", (obs.size() == 5) ? obs[4] : 32'h0, tl);

    // Stray body flit in IDLE
    clear_obs();
    send(mk(2'b00, 1, 1, 24'h000E01));
    tick();
    chk("t5_err",       32'(bus.err),        1);
    chk("t5_credit",    32'(bus.credit_out), 1);
    chk("t5_out_valid", 32'(bus.out_valid),  0);
    chk("t5_req",       32'(bus.req),        0);
    run(3);

    // Grant while idle and empty
    auto_grant = 0;
    man_grant  = 1;
    tick();
    man_grant  = 0;
    tick();
    chk("t5b_grant_err", 32'(bus.err),       1);
    chk("t5b_no_out",    32'(bus.out_valid), 0);
    auto_grant = 1;
    run(2);

    // Asynchronous reset mid-packet
    bus.ds_ready = 1'b0;
    send(mk(2'b01, 3, 2, 24'h000F01));
    send(mk(2'b00, 4, 4, 24'h000F02));
    tick();
    chk("t6_pre_route", 32'(bus.route_sel), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_route",  32'(bus.route_sel),   0);
    chk("t6_rst_route0", 32'(bus0.route_sel),  0);
    chk("t6_rst_flit",   bus.out_flit,         0);
    chk("t6_rst_valid",  32'(bus.out_valid),   0);
    chk("t6_rst_credit", 32'(bus.credit_out),  0);
    chk("t6_rst_err",    32'(bus.err),         0);
    chk("t6_rst_req",    32'(bus.req),         0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    bus.ds_ready = 1'b1;
    tick();
    clear_obs();
    ff = mk(2'b11, 0, 4, 24'h000F10);
    send(ff);
    run(6);
    chk("t6_nflits",  32'(obs.size()),      1);
    chk("t6_ncredit", 32'(cred_cyc.size()), 1);
    chk("t6_flit",    (obs.size() > 0) ? obs[0] : 32'h0, ff);
    chk("t6_route22", 32'(bus.route_sel),   2);
    chk("t6_route00", 32'(bus0.route_sel),  3);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
